// File: rtl/pipe_hazard_ctrl.sv
// Hazard and sequencing controller for a 5-stage RV32I pipeline: stage valid
// tracking, stall/flush/freeze enables, EX operand forwarding and event counters.
module pipe_hazard_ctrl #(
  parameter int CNT_WIDTH = 16
) (
  input  logic                 stage_clk,
  input  logic                 stage_rst,
  input  logic [4:0]           id_rs1,
  input  logic [4:0]           id_rs2,
  input  logic                 id_rs1_used,
  input  logic                 id_rs2_used,
  input  logic [4:0]           ex_rd,
  input  logic                 ex_is_load,
  input  logic                 ex_br_taken,
  input  logic [4:0]           ex_rs1,
  input  logic [4:0]           ex_rs2,
  input  logic [4:0]           mem_rd,
  input  logic [4:0]           wb_rd,
  input  logic                 mem_rd_we,
  input  logic                 wb_rd_we,
  input  logic                 mem_busy,
  output logic                 pc_en,
  output logic                 if_id_en,
  output logic                 id_ex_en,
  output logic                 ex_mem_en,
  output logic                 mem_wb_en,
  output logic                 redirect,
  output logic                 v_id,
  output logic                 v_ex,
  output logic                 v_mem,
  output logic                 v_wb,
  output logic [1:0]           fwd_a_sel,
  output logic [1:0]           fwd_b_sel,
  output logic [CNT_WIDTH-1:0] stall_cnt,
  output logic [CNT_WIDTH-1:0] flush_cnt
);

  localparam logic [1:0] FWD_RF  = 2'd0;
  localparam logic [1:0] FWD_MEM = 2'd1;
  localparam logic [1:0] FWD_WB  = 2'd2;

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

  logic v_id_q, v_id_d;
  logic v_ex_q, v_ex_d;
  logic v_mem_q, v_mem_d;
  logic v_wb_q, v_wb_d;
  logic [CNT_WIDTH-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_WIDTH-1:0] flush_cnt_q, flush_cnt_d;

  logic rs1_match;
  logic rs2_match;
  logic hz_lu;
  logic br;

  assign rs1_match = id_rs1_used && (id_rs1 == ex_rd);
  assign rs2_match = id_rs2_used && (id_rs2 == ex_rd);
  assign hz_lu     = v_id_q && v_ex_q && ex_is_load && (ex_rd != 5'd0) && (rs1_match || rs2_match);
  assign br        = v_ex_q && ex_br_taken;

  // Priority is busy > branch > load-use > normal; reset forces everything idle.
  always_comb begin
    pc_en       = 1'b0;
    if_id_en    = 1'b0;
    id_ex_en    = 1'b0;
    ex_mem_en   = 1'b0;
    mem_wb_en   = 1'b0;
    redirect    = 1'b0;
    v_id_d      = v_id_q;
    v_ex_d      = v_ex_q;
    v_mem_d     = v_mem_q;
    v_wb_d      = v_wb_q;
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;

    if (stage_rst || mem_busy) begin
      pc_en = 1'b0;
    end else if (br) begin
      pc_en     = 1'b1;
      if_id_en  = 1'b1;
      id_ex_en  = 1'b1;
      ex_mem_en = 1'b1;
      mem_wb_en = 1'b1;
      redirect  = 1'b1;
      v_id_d    = 1'b0;
      v_ex_d    = 1'b0;
      v_mem_d   = 1'b1;
      v_wb_d    = v_mem_q;
      if (flush_cnt_q != CNT_MAX) begin
        flush_cnt_d = flush_cnt_q + CNT_ONE;
      end
    end else if (hz_lu) begin
      id_ex_en  = 1'b1;
      ex_mem_en = 1'b1;
      mem_wb_en = 1'b1;
      v_ex_d    = 1'b0;
      v_mem_d   = v_ex_q;
      v_wb_d    = v_mem_q;
      if (stall_cnt_q != CNT_MAX) begin
        stall_cnt_d = stall_cnt_q + CNT_ONE;
      end
    end else begin
      pc_en     = 1'b1;
      if_id_en  = 1'b1;
      id_ex_en  = 1'b1;
      ex_mem_en = 1'b1;
      mem_wb_en = 1'b1;
      v_id_d    = 1'b1;
      v_ex_d    = v_id_q;
      v_mem_d   = v_ex_q;
      v_wb_d    = v_mem_q;
    end
  end

  always_ff @(posedge stage_clk or posedge stage_rst) begin
    if (stage_rst) begin
      v_id_q      <= 1'b0;
      v_ex_q      <= 1'b0;
      v_mem_q     <= 1'b0;
      v_wb_q      <= 1'b0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      v_id_q      <= v_id_d;
      v_ex_q      <= v_ex_d;
      v_mem_q     <= v_mem_d;
      v_wb_q      <= v_wb_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  // MEM result is younger than WB, so it wins; x0 is hard-wired zero and never forwarded.
  function automatic logic [1:0] fwd_select(
    input logic [4:0] rs,
    input logic       mem_ok,
    input logic       wb_ok,
    input logic [4:0] m_rd,
    input logic [4:0] w_rd
  );
    logic [1:0] sel;
    sel = FWD_RF;
    if (mem_ok && (m_rd != 5'd0) && (m_rd == rs)) begin
      sel = FWD_MEM;
    end else if (wb_ok && (w_rd != 5'd0) && (w_rd == rs)) begin
      sel = FWD_WB;
    end
    return sel;
  endfunction

  logic mem_fwd_ok;
  logic wb_fwd_ok;

  assign mem_fwd_ok = !stage_rst && v_mem_q && mem_rd_we;
  assign wb_fwd_ok  = !stage_rst && v_wb_q && wb_rd_we;

  assign fwd_a_sel = fwd_select(ex_rs1, mem_fwd_ok, wb_fwd_ok, mem_rd, wb_rd);
  assign fwd_b_sel = fwd_select(ex_rs2, mem_fwd_ok, wb_fwd_ok, mem_rd, wb_rd);

  assign v_id      = v_id_q;
  assign v_ex      = v_ex_q;
  assign v_mem     = v_mem_q;
  assign v_wb      = v_wb_q;
  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: a default-width instance plus a 2-bit
// counter instance driven by the same stimulus to exercise saturation.
module tb_pipe_hazard_ctrl;

  logic       stage_clk;
  logic       stage_rst;
  logic [4:0] id_rs1, id_rs2;
  logic       id_rs1_used, id_rs2_used;
  logic [4:0] ex_rd;
  logic       ex_is_load, ex_br_taken;
  logic [4:0] ex_rs1, ex_rs2;
  logic [4:0] mem_rd, wb_rd;
  logic       mem_rd_we, wb_rd_we;
  logic       mem_busy;

  logic        pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en, redirect;
  logic        v_id, v_ex, v_mem, v_wb;
  logic [1:0]  fwd_a_sel, fwd_b_sel;
  logic [15:0] stall_cnt, flush_cnt;

  logic        s_pc_en, s_if_id_en, s_id_ex_en, s_ex_mem_en, s_mem_wb_en, s_redirect;
  logic        s_v_id, s_v_ex, s_v_mem, s_v_wb;
  logic [1:0]  s_fwd_a_sel, s_fwd_b_sel;
  logic [1:0]  s_stall_cnt, s_flush_cnt;

  int checks = 0;
  int errors = 0;

  pipe_hazard_ctrl dut (
    .stage_clk(stage_clk), .stage_rst(stage_rst),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
    .ex_rd(ex_rd), .ex_is_load(ex_is_load), .ex_br_taken(ex_br_taken),
    .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .mem_rd(mem_rd), .wb_rd(wb_rd),
    .mem_rd_we(mem_rd_we), .wb_rd_we(wb_rd_we), .mem_busy(mem_busy),
    .pc_en(pc_en), .if_id_en(if_id_en), .id_ex_en(id_ex_en), .ex_mem_en(ex_mem_en),
    .mem_wb_en(mem_wb_en), .redirect(redirect),
    .v_id(v_id), .v_ex(v_ex), .v_mem(v_mem), .v_wb(v_wb),
    .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  pipe_hazard_ctrl #(.CNT_WIDTH(2)) dut_sat (
    .stage_clk(stage_clk), .stage_rst(stage_rst),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
    .ex_rd(ex_rd), .ex_is_load(ex_is_load), .ex_br_taken(ex_br_taken),
    .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .mem_rd(mem_rd), .wb_rd(wb_rd),
    .mem_rd_we(mem_rd_we), .wb_rd_we(wb_rd_we), .mem_busy(mem_busy),
    .pc_en(s_pc_en), .if_id_en(s_if_id_en), .id_ex_en(s_id_ex_en), .ex_mem_en(s_ex_mem_en),
    .mem_wb_en(s_mem_wb_en), .redirect(s_redirect),
    .v_id(s_v_id), .v_ex(s_v_ex), .v_mem(s_v_mem), .v_wb(s_v_wb),
    .fwd_a_sel(s_fwd_a_sel), .fwd_b_sel(s_fwd_b_sel),
    .stall_cnt(s_stall_cnt), .flush_cnt(s_flush_cnt)
  );

  initial begin
    stage_clk = 1'b0;
    forever #5 stage_clk = ~stage_clk;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic busy, input logic brTaken, input logic isLoad,
                               input logic [4:0] exRd, input logic [4:0] rs1, input logic rs1Used,
                               input logic [4:0] rs2, input logic rs2Used);
    mem_busy    = busy;
    ex_br_taken = brTaken;
    ex_is_load  = isLoad;
    ex_rd       = exRd;
    id_rs1      = rs1;
    id_rs1_used = rs1Used;
    id_rs2      = rs2;
    id_rs2_used = rs2Used;
    #1;
  endtask

  task automatic applyForward(input logic [4:0] rs1, input logic [4:0] rs2,
                              input logic [4:0] mRd, input logic mWe,
                              input logic [4:0] wRd, input logic wWe);
    ex_rs1    = rs1;
    ex_rs2    = rs2;
    mem_rd    = mRd;
    mem_rd_we = mWe;
    wb_rd     = wRd;
    wb_rd_we  = wWe;
    #1;
  endtask

  task automatic tick();
    @(posedge stage_clk);
    #1;
  endtask

  function automatic logic [3:0] validVec();
    return {v_id, v_ex, v_mem, v_wb};
  endfunction

  function automatic logic [4:0] enVec();
    return {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en};
  endfunction

  initial begin
    logic [3:0] expV;

    stage_rst = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0);
    applyForward(5'd0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0);
    #1;
    checkOutput("reset_valid", 32'(validVec()), 32'h0);
    checkOutput("reset_enables", 32'(enVec()), 32'h0);
    checkOutput("reset_redirect", 32'(redirect), 32'h0);
    checkOutput("reset_fwd", 32'({fwd_a_sel, fwd_b_sel}), 32'h0);
    checkOutput("reset_counters", 32'({stall_cnt, flush_cnt}), 32'h0);

    tick();
    stage_rst = 1'b0;
    #1;
    checkOutput("release_enables", 32'(enVec()), 32'h1f);
    for (int e = 1; e <= 6; e++) begin
      tick();
      expV = (e >= 4) ? 4'b1111 : 4'(4'b1111 << (4 - e));
      checkOutput($sformatf("fill_valid_e%0d", e), 32'(validVec()), 32'(expV));
      checkOutput($sformatf("fill_enables_e%0d", e), 32'(enVec()), 32'h1f);
    end
    checkOutput("fill_counters", 32'({stall_cnt, flush_cnt}), 32'h0);

    // load x5 in EX, ID reads rs1=x5
    applyStimulus(1'b0, 1'b0, 1'b1, 5'd5, 5'd5, 1'b1, 5'd0, 1'b0);
    checkOutput("lu_enables", 32'(enVec()), 32'h07);
    checkOutput("lu_redirect", 32'(redirect), 32'h0);
    tick();
    checkOutput("lu_valid", 32'(validVec()), 32'hb);
    checkOutput("lu_stall_cnt", 32'(stall_cnt), 32'd1);
    checkOutput("lu_one_bubble", 32'(enVec()), 32'h1f);

    // load to x0 never stalls
    applyStimulus(1'b0, 1'b0, 1'b1, 5'd0, 5'd0, 1'b1, 5'd0, 1'b0);
    tick();
    checkOutput("x0_valid", 32'(validVec()), 32'hd);
    checkOutput("x0_no_stall", 32'(enVec()), 32'h1f);
    tick();
    checkOutput("x0_stall_cnt", 32'(stall_cnt), 32'd1);

    // rs2 path, and the used qualifier
    applyStimulus(1'b0, 1'b0, 1'b1, 5'd9, 5'd0, 1'b0, 5'd9, 1'b0);
    checkOutput("rs2_unused_no_stall", 32'(pc_en), 32'h1);
    applyStimulus(1'b0, 1'b0, 1'b1, 5'd9, 5'd0, 1'b0, 5'd9, 1'b1);
    checkOutput("rs2_stall_enables", 32'(enVec()), 32'h07);
    tick();
    checkOutput("rs2_valid", 32'(validVec()), 32'hb);
    checkOutput("rs2_stall_cnt", 32'(stall_cnt), 32'd2);
    applyStimulus(1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0);
    tick(); tick(); tick();
    checkOutput("refill_valid", 32'(validVec()), 32'hf);

    // taken branch together with a load-use hazard: branch wins
    applyStimulus(1'b0, 1'b1, 1'b1, 5'd5, 5'd5, 1'b1, 5'd0, 1'b0);
    checkOutput("br_redirect", 32'(redirect), 32'h1);
    checkOutput("br_enables", 32'(enVec()), 32'h1f);
    tick();
    checkOutput("br_valid", 32'(validVec()), 32'h3);
    checkOutput("br_flush_cnt", 32'(flush_cnt), 32'd1);
    checkOutput("br_stall_cnt_held", 32'(stall_cnt), 32'd2);
    applyStimulus(1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0);
    tick(); tick(); tick(); tick();
    checkOutput("br_refill_valid", 32'(validVec()), 32'hf);

    // memory busy freezes a pending branch for 3 cycles
    applyStimulus(1'b1, 1'b1, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0);
    for (int c = 1; c <= 3; c++) begin
      checkOutput($sformatf("busy_enables_c%0d", c), 32'(enVec()), 32'h0);
      checkOutput($sformatf("busy_redirect_c%0d", c), 32'(redirect), 32'h0);
      tick();
      checkOutput($sformatf("busy_valid_c%0d", c), 32'(validVec()), 32'hf);
      checkOutput($sformatf("busy_flush_cnt_c%0d", c), 32'(flush_cnt), 32'd1);
    end
    applyStimulus(1'b0, 1'b1, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0);
    checkOutput("busy_drop_redirect", 32'(redirect), 32'h1);
    tick();
    checkOutput("busy_drop_valid", 32'(validVec()), 32'h3);
    checkOutput("busy_drop_flush_cnt", 32'(flush_cnt), 32'd2);
    applyStimulus(1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0);

    // forwarding with v_mem=v_wb=1
    applyForward(5'd7, 5'd0, 5'd7, 1'b1, 5'd7, 1'b1);
    checkOutput("fwd_a_mem_wins", 32'(fwd_a_sel), 32'd1);
    applyForward(5'd7, 5'd0, 5'd7, 1'b0, 5'd7, 1'b1);
    checkOutput("fwd_a_wb", 32'(fwd_a_sel), 32'd2);
    applyForward(5'd0, 5'd0, 5'd0, 1'b1, 5'd0, 1'b1);
    checkOutput("fwd_a_x0", 32'(fwd_a_sel), 32'd0);
    checkOutput("fwd_b_x0", 32'(fwd_b_sel), 32'd0);
    applyForward(5'd4, 5'd3, 5'd4, 1'b1, 5'd3, 1'b1);
    checkOutput("fwd_a_mem", 32'(fwd_a_sel), 32'd1);
    checkOutput("fwd_b_wb", 32'(fwd_b_sel), 32'd2);
    applyForward(5'd4, 5'd6, 5'd4, 1'b1, 5'd3, 1'b1);
    checkOutput("fwd_b_none", 32'(fwd_b_sel), 32'd0);

    // async reset clears everything before the next edge
    stage_rst = 1'b1;
    #1;
    checkOutput("rst2_valid", 32'(validVec()), 32'h0);
    checkOutput("rst2_counters", 32'({stall_cnt, flush_cnt}), 32'h0);
    checkOutput("rst2_fwd", 32'({fwd_a_sel, fwd_b_sel}), 32'h0);
    applyForward(5'd0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0);
    tick();
    stage_rst = 1'b0;
    tick(); tick(); tick(); tick();
    checkOutput("rst2_refill_valid", 32'(validVec()), 32'hf);

    // five back-to-back load-use hazards; 2-bit counter saturates at 3
    applyStimulus(1'b0, 1'b0, 1'b1, 5'd5, 5'd5, 1'b1, 5'd0, 1'b0);
    for (int i = 1; i <= 5; i++) begin
      tick();
      checkOutput($sformatf("sat_stall_cnt_%0d", i), 32'(s_stall_cnt), 32'((i > 3) ? 3 : i));
      checkOutput($sformatf("wide_stall_cnt_%0d", i), 32'(stall_cnt), 32'(i));
      tick();
    end

    // reset asserted while a stall is pending
    checkOutput("pending_stall_enables", 32'(enVec()), 32'h07);
    #2;
    stage_rst = 1'b1;
    #1;
    checkOutput("rst3_valid", 32'(validVec()), 32'h0);
    checkOutput("rst3_sat_valid", 32'({s_v_id, s_v_ex, s_v_mem, s_v_wb}), 32'h0);
    checkOutput("rst3_counters", 32'({stall_cnt, flush_cnt}), 32'h0);
    checkOutput("rst3_sat_counters", 32'({s_stall_cnt, s_flush_cnt}), 32'h0);
    checkOutput("rst3_enables", 32'(enVec()), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
